mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, cycles waited for s_ack before abort (used only when ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m{0,1,2}_req  input  1 each  master transfer request, held high until grant.
REQ-005 m{0,1,2}_we  input  1 each  1 = write, 0 = read.
REQ-006 m{0,1,2}_addr  input  ADDR_W each  transfer address.
REQ-007 m{0,1,2}_wdata  input  DATA_W each  write data.
REQ-008 m{0,1,2}_gnt  output  1 each  one-cycle pulse: request accepted.
REQ-009 m{0,1,2}_ack  output  1 each  one-cycle pulse: transfer complete.
REQ-010 m_rdata  output  DATA_W  read data, shared; valid only while some mi_ack is high.
REQ-011 m_err  output  1  shared; high with mi_ack when transfer aborted.
REQ-012 s_req, s_we, s_addr, s_wdata  output  1/1/ADDR_W/DATA_W  slave request and its attributes.
REQ-013 s_rdata  input  DATA_W; s_ack  input  1  slave completion, may arrive in any cycle s_req is high.

Function
REQ-014 FSM SHALL have states IDLE, BUSY, RESP.
REQ-015 IDLE: if any mi_req high, winner chosen round-robin, searching from (last+1) mod 3 upward; winner index latched into last; winner's we/addr/wdata latched; next state BUSY; else stay IDLE.
REQ-016 mi_gnt SHALL pulse for exactly the first BUSY cycle, winner only.
REQ-017 BUSY: s_req high with latched attributes; attributes SHALL stay constant even if the master changes its inputs.
REQ-018 BUSY with s_ack high: s_rdata latched (0 for writes), next state RESP; s_req SHALL drop in RESP.
REQ-019 RESP: winner's mi_ack high for one cycle with m_rdata = latched data; next state IDLE.
REQ-020 Minimum latency: req sampled in IDLE cycle N, gnt and s_req in N+1, s_ack in N+1 yields ack in N+2; next arbitration no earlier than N+3.
REQ-021 A request dropped before its grant is withdrawn with no slave access.
REQ-022 Requests arriving during BUSY/RESP SHALL wait; no request starves (each waits at most 2 other transfers).
REQ-023 At most one of mi_gnt, and at most one of mi_ack, high in any cycle; all outputs registered.

Reset
REQ-024 On rst high at a clock edge: state IDLE, last = 2 (m0 wins first), all mi_gnt/mi_ack/m_err/s_req = 0, m_rdata = 0, latched attributes = 0, timeout counter = 0.
REQ-025 Reset in BUSY SHALL abandon the transfer: s_req low next cycle, no ack issued; a late s_ack SHALL be ignored in IDLE.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: counter clears entering BUSY, increments each BUSY cycle without s_ack; when it reaches TIMEOUT, next state RESP with m_err = 1, m_rdata = 0, s_req dropped; s_ack in the same cycle as the limit wins (normal completion, m_err = 0).
REQ-027 ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for s_ack; m_err tied 0.

Verification
REQ-028 Reset then m0 read addr 0x100, slave acks first BUSY cycle with 0xDEADBEEF -> m0_gnt cycle N+1, m0_ack cycle N+2, m_rdata = 0xDEADBEEF, m_err = 0.
REQ-029 m0, m1, m2 all hold req continuously, slave acks immediately -> grant order m0, m1, m2, m0, repeating; no two gnts together.
REQ-030 m1 write 0x2000/0x12345678, master changes addr/wdata after gnt, slave acks after 5 cycles -> s_addr/s_wdata stay 0x2000/0x12345678 for all 5 BUSY cycles, m1_ack once.
REQ-031 ARB_TIMEOUT_EN, TIMEOUT = 16, slave never acks -> ack with m_err = 1, m_rdata = 0 exactly 16 BUSY cycles after gnt; without macro, no ack after 1000 cycles.
REQ-032 rst asserted on 3rd BUSY cycle of m2 transfer, s_ack pulsed one cycle later -> s_req low after reset edge, no mi_ack, next request from m0 granted first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the three requesting-master ports and the single slave port of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req, m1_req, m2_req;
    logic              m0_we, m1_we, m2_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, m2_wdata;
    logic              m0_gnt, m1_gnt, m2_gnt;
    logic              m0_ack, m1_ack, m2_ack;
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;
    logic              s_req, s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ack;

    modport slave (
        input  m0_req, m1_req, m2_req, m0_we, m1_we, m2_we,
        input  m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata, m2_wdata,
        output m0_gnt, m1_gnt, m2_gnt, m0_ack, m1_ack, m2_ack, m_rdata, m_err,
        output s_req, s_we, s_addr, s_wdata,
        input  s_rdata, s_ack
    );

    modport master (
        output m0_req, m1_req, m2_req, m0_we, m1_we, m2_we,
        output m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata, m2_wdata,
        input  m0_gnt, m1_gnt, m2_gnt, m0_ack, m1_ack, m2_ack, m_rdata, m_err,
        input  s_req, s_we, s_addr, s_wdata,
        output s_rdata, s_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-master round-robin arbiter onto one memory slave (IDLE -> BUSY -> RESP).
// Optional slave timeout abort enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nx;
    logic [1:0]        last, sel;
    logic              found;
    logic [2:0]        req, gnt_q, ack_q;
    logic              sel_we, we_q, sreq_q, tout;
    logic [ADDR_W-1:0] sel_addr, addr_q;
    logic [DATA_W-1:0] sel_wdata, wdata_q, rdata_q;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input int unsigned off);
        int unsigned c;
        c = {30'd0, base} + off;
        if (c >= 3) c = c - 3;
        return c[1:0];
    endfunction

    assign req = {bus.m2_req, bus.m1_req, bus.m0_req};

    // Search starts one past the previous winner, so every master waits at most two transfers.
    always_comb begin
        sel   = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 3; i++) begin
            if (!found && req[rr_idx(last, i)]) begin
                found = 1'b1;
                sel   = rr_idx(last, i);
            end
        end
    end

    always_comb begin
        sel_we    = bus.m0_we;
        sel_addr  = bus.m0_addr;
        sel_wdata = bus.m0_wdata;
        case (sel)
            2'd1: begin
                sel_we    = bus.m1_we;
                sel_addr  = bus.m1_addr;
                sel_wdata = bus.m1_wdata;
            end
            2'd2: begin
                sel_we    = bus.m2_we;
                sel_addr  = bus.m2_addr;
                sel_wdata = bus.m2_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = BUSY;
            BUSY:    if (bus.s_ack || tout) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 2'd2;
            gnt_q   <= '0;
            ack_q   <= '0;
            sreq_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            gnt_q <= '0;
            ack_q <= '0;
            case (state)
                IDLE: if (found) begin
                    last    <= sel;
                    we_q    <= sel_we;
                    addr_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    gnt_q   <= 3'b001 << sel;
                    sreq_q  <= 1'b1;
                end
                // A timeout (no s_ack) and a write both return zero data.
                BUSY: if (bus.s_ack || tout) begin
                    rdata_q <= (we_q || !bus.s_ack) ? '0 : bus.s_rdata;
                    ack_q   <= 3'b001 << last;
                    sreq_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;
    logic          err_q;

    // Expiry is the cycle whose increment would reach TIMEOUT; s_ack in that cycle still wins.
    assign tout = (state == BUSY) && !bus.s_ack && (tmr == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tout;
            if (state == BUSY && !bus.s_ack) tmr <= tmr + TW'(1);
            else if (state == IDLE)          tmr <= '0;
        end
    end

    assign bus.m_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign tout      = 1'b0;
    assign bus.m_err = 1'b0;
`endif

    assign bus.m0_gnt  = gnt_q[0];
    assign bus.m1_gnt  = gnt_q[1];
    assign bus.m2_gnt  = gnt_q[2];
    assign bus.m0_ack  = ack_q[0];
    assign bus.m1_ack  = ack_q[1];
    assign bus.m2_ack  = ack_q[2];
    assign bus.m_rdata = rdata_q;
    assign bus.s_req   = sreq_q;
    assign bus.s_we    = we_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [2:0] gnts();
        return {bus.m2_gnt, bus.m1_gnt, bus.m0_gnt};
    endfunction

    function automatic logic [2:0] acks();
        return {bus.m2_ack, bus.m1_ack, bus.m0_ack};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m2_req = 1'b0;
        bus.m0_we  = 1'b0; bus.m1_we  = 1'b0; bus.m2_we  = 1'b0;
        bus.m0_addr = '0;  bus.m1_addr = '0;  bus.m2_addr = '0;
        bus.m0_wdata = '0; bus.m1_wdata = '0; bus.m2_wdata = '0;
        bus.s_ack = 1'b0;  bus.s_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++; if (gnts() !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnts()); end
        checks++; if (acks() !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp 000", acks()); end
        checks++; if (bus.s_req !== 1'b0) begin errors++; $display("FAIL reset_sreq got %b exp 0", bus.s_req); end
        checks++; if (bus.m_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.m_err); end
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.m_rdata); end
        checks++; if (bus.s_addr !== 32'h0 || bus.s_wdata !== 32'h0 || bus.s_we !== 1'b0) begin
            errors++; $display("FAIL reset_attr got %h/%h/%b exp 0/0/0", bus.s_addr, bus.s_wdata, bus.s_we);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h100;
        step();
        checks++; if (gnts() !== 3'b001) begin errors++; $display("FAIL read_gnt got %b exp 001", gnts()); end
        checks++; if (bus.s_req !== 1'b1) begin errors++; $display("FAIL read_sreq got %b exp 1", bus.s_req); end
        checks++; if (bus.s_addr !== 32'h100 || bus.s_we !== 1'b0) begin
            errors++; $display("FAIL read_attr got %h/%b exp 00000100/0", bus.s_addr, bus.s_we);
        end
        bus.m0_req = 1'b0; bus.s_ack = 1'b1; bus.s_rdata = 32'hDEADBEEF;
        step();
        checks++; if (acks() !== 3'b001) begin errors++; $display("FAIL read_ack got %b exp 001", acks()); end
        checks++; if (bus.m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", bus.m_rdata); end
        checks++; if (bus.m_err !== 1'b0) begin errors++; $display("FAIL read_err got %b exp 0", bus.m_err); end
        checks++; if (bus.s_req !== 1'b0 || gnts() !== 3'b000) begin
            errors++; $display("FAIL read_resp got sreq %b gnt %b exp 0/000", bus.s_req, gnts());
        end
        bus.s_ack = 1'b0; bus.s_rdata = '0;
        step();
        checks++; if (acks() !== 3'b000) begin errors++; $display("FAIL read_ack_pulse got %b exp 000", acks()); end
    endtask

    task automatic test_round_robin();
        int         ng;
        logic [2:0] g, exp_g;
        ng = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m2_req = 1'b1;
        bus.m0_addr = 32'h10; bus.m1_addr = 32'h20; bus.m2_addr = 32'h30;
        bus.s_ack = 1'b1; bus.s_rdata = 32'h0000A5A5;
        for (int c = 0; c < 18; c++) begin
            step();
            g = gnts();
            if (g !== 3'b000) begin
                exp_g = 3'b001 << (ng % 3);
                checks++; if (g !== exp_g) begin errors++; $display("FAIL rr_order got %b exp %b", g, exp_g); end
                ng++;
            end
            if (acks() !== 3'b000) begin
                checks++; if (bus.m_rdata !== 32'h0000A5A5) begin errors++; $display("FAIL rr_rdata got %h exp 0000a5a5", bus.m_rdata); end
            end
        end
        checks++; if (ng != 6) begin errors++; $display("FAIL rr_count got %0d exp 6", ng); end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h300;
        step();
        checks++; if (gnts() !== 3'b001) begin errors++; $display("FAIL to_gnt got %b exp 001", gnts()); end
        bus.m0_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        begin
            int at;
            at = 0;
            for (int i = 1; i <= 40 && at == 0; i++) begin
                step();
                if (acks() !== 3'b000) begin
                    at = i;
                    checks++; if (acks() !== 3'b001) begin errors++; $display("FAIL to_ack got %b exp 001", acks()); end
                    checks++; if (bus.m_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", bus.m_err); end
                    checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", bus.m_rdata); end
                    checks++; if (bus.s_req !== 1'b0) begin errors++; $display("FAIL to_sreq got %b exp 0", bus.s_req); end
                end
            end
            checks++; if (at != TIMEOUT) begin errors++; $display("FAIL to_latency got %0d exp %0d", at, TIMEOUT); end
        end
`else
        begin
            int nack;
            nack = 0;
            for (int i = 0; i < 1000; i++) begin
                step();
                if (acks() !== 3'b000) nack++;
            end
            checks++; if (nack != 0) begin errors++; $display("FAIL noto_ack got %0d exp 0", nack); end
            checks++; if (bus.s_req !== 1'b1) begin errors++; $display("FAIL noto_sreq got %b exp 1", bus.s_req); end
            checks++; if (bus.m_err !== 1'b0) begin errors++; $display("FAIL noto_err got %b exp 0", bus.m_err); end
        end
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_hold_attrs();
        int nack;
        nack = 0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h2000; bus.m1_wdata = 32'h12345678;
        bus.s_rdata = 32'hCAFEF00D;
        step();
        checks++; if (gnts() !== 3'b010) begin errors++; $display("FAIL hold_gnt got %b exp 010", gnts()); end
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'hFFFF0000; bus.m1_wdata = 32'h0;
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) step();
            checks++; if (bus.s_req !== 1'b1) begin errors++; $display("FAIL hold_sreq[%0d] got %b exp 1", i, bus.s_req); end
            checks++; if (bus.s_addr !== 32'h2000 || bus.s_wdata !== 32'h12345678 || bus.s_we !== 1'b1) begin
                errors++; $display("FAIL hold_attr[%0d] got %h/%h/%b exp 00002000/12345678/1", i, bus.s_addr, bus.s_wdata, bus.s_we);
            end
        end
        bus.s_ack = 1'b1;
        step();
        checks++; if (acks() !== 3'b010) begin errors++; $display("FAIL hold_ack got %b exp 010", acks()); end
        checks++; if (bus.m_rdata !== 32'h0 || bus.m_err !== 1'b0) begin
            errors++; $display("FAIL hold_wresp got %h/%b exp 0/0", bus.m_rdata, bus.m_err);
        end
        checks++; if (bus.s_req !== 1'b0) begin errors++; $display("FAIL hold_sreq_drop got %b exp 0", bus.s_req); end
        bus.s_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (acks() !== 3'b000) nack++;
        end
        checks++; if (nack != 0) begin errors++; $display("FAIL hold_extra_ack got %0d exp 0", nack); end
    endtask

    task automatic test_withdraw();
        int nact;
        nact = 0;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h40;
        step();
        checks++; if (gnts() !== 3'b001) begin errors++; $display("FAIL wd_gnt got %b exp 001", gnts()); end
        bus.m0_req = 1'b0; bus.m2_req = 1'b1; bus.s_ack = 1'b1; bus.s_rdata = 32'h11;
        step();
        checks++; if (acks() !== 3'b001 || bus.m_rdata !== 32'h11) begin
            errors++; $display("FAIL wd_ack got %b/%h exp 001/00000011", acks(), bus.m_rdata);
        end
        bus.m2_req = 1'b0; bus.s_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnts() !== 3'b000 || bus.s_req !== 1'b0) nact++;
        end
        checks++; if (nact != 0) begin errors++; $display("FAIL wd_activity got %0d exp 0", nact); end
    endtask

    task automatic test_reset_in_busy();
        bus.m2_req = 1'b1; bus.m2_we = 1'b1; bus.m2_addr = 32'h500; bus.m2_wdata = 32'h77;
        step();
        checks++; if (gnts() !== 3'b100) begin errors++; $display("FAIL rb_gnt got %b exp 100", gnts()); end
        bus.m2_req = 1'b0;
        step();
        step();
        checks++; if (bus.s_req !== 1'b1) begin errors++; $display("FAIL rb_busy3 got %b exp 1", bus.s_req); end
        rst = 1'b1;
        step();
        checks++; if (bus.s_req !== 1'b0 || acks() !== 3'b000) begin
            errors++; $display("FAIL rb_abandon got sreq %b ack %b exp 0/000", bus.s_req, acks());
        end
        rst = 1'b0; bus.s_ack = 1'b1;
        step();
        checks++; if (acks() !== 3'b000 || bus.s_req !== 1'b0) begin
            errors++; $display("FAIL rb_late_ack got ack %b sreq %b exp 000/0", acks(), bus.s_req);
        end
        bus.s_ack = 1'b0; bus.m0_req = 1'b1; bus.m2_req = 1'b1;
        step();
        checks++; if (gnts() !== 3'b001) begin errors++; $display("FAIL rb_next_gnt got %b exp 001", gnts()); end
        bus.m0_req = 1'b0; bus.m2_req = 1'b0; bus.s_ack = 1'b1;
        step();
        checks++; if (acks() !== 3'b001) begin errors++; $display("FAIL rb_next_ack got %b exp 001", acks()); end
        bus.s_ack = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_hold_attrs();
        test_withdraw();
        test_reset_in_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
